// File: rtl/sm3_cmprss_core_wrapper_if.sv
// rtl/sm3_cmprss_core_wrapper_if.sv - padded-word input stream and digest output bundle for the SM3 compression core
interface sm3_cmprss_core_wrapper_if;
    logic [31:0]  pad_otpt_d;
    logic         pad_otpt_vld;
    logic         pad_otpt_lst;
    logic         pad_otpt_ena;
    logic [255:0] cmprss_otpt_res;
    logic         cmprss_otpt_vld;

    modport master (
        output pad_otpt_d,
        output pad_otpt_vld,
        output pad_otpt_lst,
        input  pad_otpt_ena,
        input  cmprss_otpt_res,
        input  cmprss_otpt_vld
    );

    modport slave (
        input  pad_otpt_d,
        input  pad_otpt_vld,
        input  pad_otpt_lst,
        output pad_otpt_ena,
        output cmprss_otpt_res,
        output cmprss_otpt_vld
    );
endinterface

// File: rtl/sm3_cmprss_core_wrapper.sv
// rtl/sm3_cmprss_core_wrapper.sv - SM3 compression core: 16-word load, 64 rounds with on-the-fly expansion, chaining update
module sm3_cmprss_core_wrapper (
    input  logic                         clk,
    input  logic                         rst_n,
    sm3_cmprss_core_wrapper_if.slave     bus
);
    typedef enum logic [1:0] {S_LOAD, S_RUN, S_UPDT} state_t;

    localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [31:0]  T_LO = 32'h79cc4519;
    localparam logic [31:0]  T_HI = 32'h7a879d8a;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
    endfunction

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [5:0]    r_rnd;
    logic          r_lst;
    logic [255:0]  r_v;
    logic [31:0]   r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [31:0]   r_w [16];
    logic [255:0]  r_dig;
    logic          r_pend;
    logic [255:0]  r_res;
    logic          r_res_vld;
    logic          r_ena;

    logic          w_acc;
    logic          w_early;
    logic [31:0]   w_a12;
    logic [31:0]   w_tj;
    logic [31:0]   w_ss1;
    logic [31:0]   w_ss2;
    logic [31:0]   w_ff;
    logic [31:0]   w_gg;
    logic [31:0]   w_tt1;
    logic [31:0]   w_tt2;
    logic [31:0]   w_wnew;
    logic [255:0]  w_vnew;

    assign w_acc = bus.pad_otpt_vld & r_ena;

    // r_w[0] always holds Wj for the current round; r_w[4] is Wj+4.
    always_comb begin
        w_early = (r_rnd < 6'd16);
        w_a12   = rotl(r_a, 5'd12);
        w_tj    = w_early ? T_LO : T_HI;
        w_ss1   = rotl(w_a12 + r_e + rotl(w_tj, r_rnd[4:0]), 5'd7);
        w_ss2   = w_ss1 ^ w_a12;
        w_ff    = w_early ? (r_a ^ r_b ^ r_c) : ((r_a & r_b) | (r_a & r_c) | (r_b & r_c));
        w_gg    = w_early ? (r_e ^ r_f ^ r_g) : ((r_e & r_f) | (~r_e & r_g));
        w_tt1   = w_ff + r_d + w_ss2 + (r_w[0] ^ r_w[4]);
        w_tt2   = w_gg + r_h + w_ss1 + r_w[0];
        w_wnew  = p1(r_w[0] ^ r_w[7] ^ rotl(r_w[13], 5'd15)) ^ rotl(r_w[3], 5'd7) ^ r_w[10];
        w_vnew  = r_v ^ {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_LOAD;
            r_cnt     <= '0;
            r_rnd     <= '0;
            r_lst     <= 1'b0;
            r_v       <= IV;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_e       <= '0;
            r_f       <= '0;
            r_g       <= '0;
            r_h       <= '0;
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            r_dig     <= '0;
            r_pend    <= 1'b0;
            r_res     <= '0;
            r_res_vld <= 1'b0;
            r_ena     <= 1'b1;
        end else begin
            // Digest is staged one cycle after UPDT so V can already return to IV.
            r_res_vld <= r_pend;
            if (r_pend) r_res <= r_dig;
            r_pend <= 1'b0;

            case (r_state)
                S_LOAD: begin
                    if (w_acc) begin
                        for (int i = 0; i < 15; i++) r_w[i] <= r_w[i + 1];
                        r_w[15] <= bus.pad_otpt_d;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_state <= S_RUN;
                            r_lst   <= bus.pad_otpt_lst;
                            r_rnd   <= '0;
                            r_ena   <= 1'b0;
                            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= r_v;
                        end
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < 15; i++) r_w[i] <= r_w[i + 1];
                    r_w[15] <= w_wnew;
                    r_d     <= r_c;
                    r_c     <= rotl(r_b, 5'd9);
                    r_b     <= r_a;
                    r_a     <= w_tt1;
                    r_h     <= r_g;
                    r_g     <= rotl(r_f, 5'd19);
                    r_f     <= r_e;
                    r_e     <= p0(w_tt2);
                    r_rnd   <= r_rnd + 6'd1;
                    if (r_rnd == 6'd63) r_state <= S_UPDT;
                end
                S_UPDT: begin
                    if (r_lst) begin
                        r_dig  <= w_vnew;
                        r_pend <= 1'b1;
                        r_v    <= IV;
                    end else begin
                        r_v    <= w_vnew;
                    end
                    r_state <= S_LOAD;
                    r_ena   <= 1'b1;
                end
                default: begin
                    r_state <= S_LOAD;
                    r_ena   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pad_otpt_ena    = r_ena;
    assign bus.cmprss_otpt_res = r_res;
    assign bus.cmprss_otpt_vld = r_res_vld;
endmodule

// File: tb/tb_sm3_cmprss_core_wrapper.sv
// tb/tb_sm3_cmprss_core_wrapper.sv - self-checking bench for the SM3 compression core
module tb_sm3_cmprss_core_wrapper;
    localparam logic [255:0] IV       = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [511:0] ABC      = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ABCD1    = {16{32'h61626364}};
    localparam logic [511:0] ABCD2    = {32'h80000000, 448'h0, 32'h00000200};
    localparam logic [255:0] DIG_ABC  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] DIG_ABCD = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sm3_cmprss_core_wrapper_if bus();

    sm3_cmprss_core_wrapper dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc;
    logic [255:0] exp_last;
    logic [255:0] pq[$];
    int           pc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.cmprss_otpt_vld === 1'b1) begin
            pq.push_back(bus.cmprss_otpt_res);
            pc.push_back(cyc);
        end
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] mp0(input logic [31:0] x);
        return x ^ rl(x, 9) ^ rl(x, 17);
    endfunction

    function automatic logic [31:0] mp1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    // Reference compression function written directly from the algorithm with full W/W' arrays.
    function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] blk);
        logic [31:0] w [68];
        logic [31:0] w1 [64];
        logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, ff, gg;
        for (int j = 0; j < 16; j++) w[j] = blk[511 - 32 * j -: 32];
        for (int j = 16; j < 68; j++)
            w[j] = mp1(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
        for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
        {a, b, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
            gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            ss1 = rl(rl(a, 12) + e + rl(t, j), 7);
            ss2 = ss1 ^ rl(a, 12);
            tt1 = ff + d + ss2 + w1[j];
            tt2 = gg + h + ss1 + w[j];
            d = c; c = rl(b, 9); b = a; a = tt1;
            h = g; g = rl(f, 19); f = e; e = mp0(tt2);
        end
        return v ^ {a, b, c, d, e, f, g, h};
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, input bit gaps);
        int budget;
        int g;
        @(negedge clk);
        if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                bus.pad_otpt_vld = 1'b0;
                bus.pad_otpt_d   = $urandom;
                bus.pad_otpt_lst = 1'($urandom);
                @(negedge clk);
            end
        end
        bus.pad_otpt_d   = d;
        bus.pad_otpt_vld = 1'b1;
        bus.pad_otpt_lst = l;
        budget = 0;
        while (bus.pad_otpt_ena !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_word_timeout: ena=%b after %0d cycles, required 1", bus.pad_otpt_ena, budget);
        end else begin
            acc_cyc = cyc + 1;
        end
        @(posedge clk);
    endtask

    task automatic send_block(input logic [511:0] blk, input bit last, input int lst_at, input bit gaps);
        for (int i = 0; i < 16; i++)
            send_word(blk[511 - 32 * i -: 32], ((i == 15) && last) || (i == lst_at), gaps);
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus.pad_otpt_vld = 1'b0;
        bus.pad_otpt_lst = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (pq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [255:0] pulse_res(input int i);
        if (pq.size() > i) return pq[i];
        return 'x;
    endfunction

    function automatic int pulse_lat(input int i);
        if (pc.size() > i) return pc[i] - acc_cyc;
        return -1;
    endfunction

    task automatic test_reset();
        bus.pad_otpt_vld = 1'b0;
        bus.pad_otpt_lst = 1'b0;
        bus.pad_otpt_d   = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.pad_otpt_ena !== 1'b1) begin n_fail++; $display("FAIL reset_ena: got %b exp 1", bus.pad_otpt_ena); end
        n_chk++;
        if (bus.cmprss_otpt_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b exp 0", bus.cmprss_otpt_vld); end
        n_chk++;
        if (bus.cmprss_otpt_res !== 256'h0) begin n_fail++; $display("FAIL reset_res: got %h exp 0", bus.cmprss_otpt_res); end
        exp_last = '0;
    endtask

    task automatic test_abc();
        logic [255:0] m;
        pq.delete(); pc.delete();
        m = sm3_cf(IV, ABC);
        send_block(ABC, 1'b1, -1, 1'b0);
        release_bus();
        wait_pulses(1, 100);
        n_chk++;
        if (pq.size() != 1) begin n_fail++; $display("FAIL abc_count: got %0d exp 1", pq.size()); end
        n_chk++;
        if (pulse_res(0) !== DIG_ABC) begin n_fail++; $display("FAIL abc_digest: got %h exp %h", pulse_res(0), DIG_ABC); end
        n_chk++;
        if (pulse_res(0) !== m) begin n_fail++; $display("FAIL abc_model: got %h exp %h", pulse_res(0), m); end
        n_chk++;
        if (pulse_lat(0) != 66) begin n_fail++; $display("FAIL abc_latency: got %0d exp 66", pulse_lat(0)); end
        exp_last = DIG_ABC;
    endtask

    task automatic test_ready_latency();
        int low = 0;
        int k = 0;
        pq.delete(); pc.delete();
        for (int i = 0; i < 16; i++) send_word(ABC[511 - 32 * i -: 32], i == 15, 1'b0);
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (bus.pad_otpt_ena === 1'b0) begin
                low++;
                bus.pad_otpt_vld = 1'b1;
                bus.pad_otpt_d   = $urandom;
                bus.pad_otpt_lst = 1'($urandom);
            end else begin
                bus.pad_otpt_vld = 1'b0;
                bus.pad_otpt_lst = 1'b0;
                break;
            end
        end
        n_chk++;
        if (low != 65) begin n_fail++; $display("FAIL ready_low_cycles: got %0d exp 65", low); end
        wait_pulses(1, 100);
        n_chk++;
        if (pq.size() != 1) begin n_fail++; $display("FAIL ready_count: got %0d exp 1", pq.size()); end
        n_chk++;
        if (pulse_lat(0) != 66) begin n_fail++; $display("FAIL ready_latency: got %0d exp 66", pulse_lat(0)); end
        n_chk++;
        if (pulse_res(0) !== DIG_ABC) begin n_fail++; $display("FAIL ready_digest: got %h exp %h", pulse_res(0), DIG_ABC); end
        exp_last = DIG_ABC;
    endtask

    task automatic test_chaining();
        logic [255:0] m;
        pq.delete(); pc.delete();
        m = sm3_cf(sm3_cf(IV, ABCD1), ABCD2);
        send_block(ABCD1, 1'b0, -1, 1'b0);
        release_bus();
        repeat (75) @(negedge clk);
        n_chk++;
        if (pq.size() != 0) begin n_fail++; $display("FAIL chain_mid_count: got %0d exp 0", pq.size()); end
        n_chk++;
        if (bus.cmprss_otpt_res !== exp_last) begin n_fail++; $display("FAIL chain_hold: got %h exp %h", bus.cmprss_otpt_res, exp_last); end
        send_block(ABCD2, 1'b1, -1, 1'b0);
        release_bus();
        wait_pulses(1, 100);
        n_chk++;
        if (pq.size() != 1) begin n_fail++; $display("FAIL chain_count: got %0d exp 1", pq.size()); end
        n_chk++;
        if (pulse_res(0) !== DIG_ABCD) begin n_fail++; $display("FAIL chain_digest: got %h exp %h", pulse_res(0), DIG_ABCD); end
        n_chk++;
        if (pulse_res(0) !== m) begin n_fail++; $display("FAIL chain_model: got %h exp %h", pulse_res(0), m); end
        exp_last = DIG_ABCD;
    endtask

    task automatic test_back_to_back();
        pq.delete(); pc.delete();
        send_block(ABC, 1'b1, -1, 1'b0);
        send_block(ABC, 1'b1, -1, 1'b0);
        release_bus();
        wait_pulses(2, 250);
        n_chk++;
        if (pq.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d exp 2", pq.size()); end
        n_chk++;
        if (pulse_res(0) !== DIG_ABC) begin n_fail++; $display("FAIL b2b_first: got %h exp %h", pulse_res(0), DIG_ABC); end
        n_chk++;
        if (pulse_res(1) !== DIG_ABC) begin n_fail++; $display("FAIL b2b_second: got %h exp %h", pulse_res(1), DIG_ABC); end
        n_chk++;
        if (pc.size() < 2 || (pc[1] - pc[0]) != 81) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d exp 81", (pc.size() < 2) ? -1 : pc[1] - pc[0]);
        end
        exp_last = DIG_ABC;
    endtask

    task automatic test_reset_abort();
        pq.delete(); pc.delete();
        send_block(ABC, 1'b1, -1, 1'b0);
        release_bus();
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.pad_otpt_ena !== 1'b1) begin n_fail++; $display("FAIL abort_ena: got %b exp 1", bus.pad_otpt_ena); end
        repeat (100) @(negedge clk);
        n_chk++;
        if (pq.size() != 0) begin n_fail++; $display("FAIL abort_no_pulse: got %0d exp 0", pq.size()); end
        send_block(ABC, 1'b1, -1, 1'b0);
        release_bus();
        wait_pulses(1, 100);
        n_chk++;
        if (pq.size() != 1) begin n_fail++; $display("FAIL abort_count: got %0d exp 1", pq.size()); end
        n_chk++;
        if (pulse_res(0) !== DIG_ABC) begin n_fail++; $display("FAIL abort_digest: got %h exp %h", pulse_res(0), DIG_ABC); end
        exp_last = DIG_ABC;
    endtask

    task automatic test_lst_word5();
        pq.delete(); pc.delete();
        send_block(ABC, 1'b1, 5, 1'b1);
        release_bus();
        wait_pulses(1, 100);
        n_chk++;
        if (pq.size() != 1) begin n_fail++; $display("FAIL lst5_count: got %0d exp 1", pq.size()); end
        n_chk++;
        if (pulse_res(0) !== DIG_ABC) begin n_fail++; $display("FAIL lst5_digest: got %h exp %h", pulse_res(0), DIG_ABC); end
        exp_last = DIG_ABC;
    endtask

    task automatic test_random();
        logic [255:0] v;
        logic [511:0] blk;
        int nb;
        for (int m = 0; m < 4; m++) begin
            pq.delete(); pc.delete();
            nb = $urandom_range(1, 3);
            v = IV;
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 16; i++) blk[511 - 32 * i -: 32] = $urandom;
                v = sm3_cf(v, blk);
                send_block(blk, b == nb - 1, -1, 1'b1);
            end
            release_bus();
            wait_pulses(1, 100);
            n_chk++;
            if (pq.size() != 1) begin n_fail++; $display("FAIL rand%0d_count: got %0d exp 1", m, pq.size()); end
            n_chk++;
            if (pulse_res(0) !== v) begin n_fail++; $display("FAIL rand%0d_digest: got %h exp %h", m, pulse_res(0), v); end
            n_chk++;
            if (pulse_lat(0) != 66) begin n_fail++; $display("FAIL rand%0d_latency: got %0d exp 66", m, pulse_lat(0)); end
            exp_last = v;
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_ready_latency();
        test_chaining();
        test_back_to_back();
        test_reset_abort();
        test_lst_word5();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
